fyp_udp_rx_checker: RTL and testbench
=====================================

// Module: fyp_udp_rx_checker
// PURPOSE
//  Receive-side counterpart of the UDP/IP packet generator.
//  - Accepts a parsed UDP/IP/Ethernet header (valid/ready) and a 32-bit AXI-Stream payload.
//  - Checks header fields and every payload byte against the expected generator settings.
//  - Checks payload byte count against UDP length - 8.
//  - Reports per-packet status and keeps running good/bad packet counters for loopback test.
// PARAMETERS
//  EXP_MAC_DST   48'h00E04C68088F  expected Ethernet destination MAC
//  EXP_IP_DST    32'hc0a80105      expected IPv4 destination address
//  EXP_UDP_SRC   16'h1111          expected UDP source port
//  EXP_UDP_DST   16'h2222          expected UDP destination port
//  EXP_DATA      8'h11             expected value of every payload byte
// PORTS
//  clk                  in   1   clock
//  reset                in   1   synchronous, active-high reset
//  s_udp_hdr_valid      in   1   header fields valid
//  s_udp_hdr_ready      out  1   header accept
//  s_eth_dest_mac       in   48  received destination MAC
//  s_ip_dest_ip         in   32  received IPv4 destination
//  s_udp_source_port    in   16  received UDP source port
//  s_udp_dest_port      in   16  received UDP destination port
//  s_udp_length         in   16  UDP length field, header included (bytes)
//  s_axis_tdata         in   32  payload; byte lane 0 = [7:0] = first byte on wire
//  s_axis_tkeep         in   4   byte enables; must be contiguous from lane 0
//  s_axis_tvalid        in   1   payload beat valid
//  s_axis_tready        out  1   payload beat accept
//  s_axis_tlast         in   1   last beat of packet
//  s_axis_tuser         in   1   upstream error flag (any beat)
//  status_valid         out  1   one-cycle pulse per completed packet
//  status_err           out  4   [0] header mismatch, [1] payload/tkeep error, [2] length error, [3] tuser seen
//  good_count           out  32  packets with status_err == 0
//  bad_count            out  32  packets with status_err != 0
//  busy                 out  1   high in PAYLOAD and STATUS
// BEHAVIOUR
//  Reset values
//  - All outputs and state are reset to 0; FSM enters IDLE.
//  - s_udp_hdr_ready is registered: 0 during reset, 1 after the first clk edge with reset low.
//  FSM IDLE
//  - s_udp_hdr_ready = 1, s_axis_tready = 0.
//  - On hdr_valid & hdr_ready: latch hdr_err (any field != EXP_*) and exp_len = s_udp_length - 8.
//  - If s_udp_length < 8: set len_err immediately and clamp exp_len = 0.
//  - Clear the byte counter and payload/tuser flags; s_udp_hdr_ready <= 0; go to PAYLOAD.
//  FSM PAYLOAD
//  - s_axis_tready = 1 (registered, asserted from the cycle after header accept).
//  - Each beat with tvalid & tready:
//    - byte_cnt += popcount(tkeep); 16-bit, saturates at 0xFFFF.
//    - Any kept lane != EXP_DATA sets pay_err.
//    - Non-contiguous tkeep (e.g. 4'b0101) or tkeep = 0 sets pay_err.
//    - tuser = 1 sets usr_err.
//  - On the tlast beat: tready <= 0; go to STATUS.
//  - Gaps in tvalid are allowed and have no effect.
//  FSM STATUS
//  - Lasts one cycle: status_valid = 1.
//  - status_err = {usr_err, len_err | (byte_cnt != exp_len), pay_err, hdr_err}.
//  - Increment good_count or bad_count; both are 32-bit and wrap at 2^32.
//  - Go to IDLE; hdr_ready = 1 on the following cycle.
//  - status_err holds its value until the next STATUS; status_valid is 0 otherwise.
//  Latency and handshake rules
//  - status_valid is asserted exactly 1 cycle after the tlast handshake.
//  - Header-to-first-beat accept: minimum 1 cycle.
//  - Payload is never accepted in IDLE; a header is never accepted in PAYLOAD or STATUS.
//  - A header mismatch does not abort: the payload is still drained to tlast.
//  Reset mid-packet
//  - Abandon the partial packet: no status pulse, counters cleared, return to IDLE.
// TESTING
//  1 Good pkt: MAC 00E04C68088F, IP c0a80105, ports 1111/2222, len 0x001A;
//    4 beats 0x11111111 tkeep F + last beat tkeep 3
//    -> status_valid 1 cycle after tlast, err 0, good_count = 1.
//  2 Same pkt, byte 7 = 0x12 -> err 4'b0010, bad_count = 1, good_count unchanged.
//  3 len 0x001B, same 18 bytes -> err 4'b0100; len 0x0005, 1 byte -> err 4'b0100.
//  4 udp_dst 0x2223 -> payload fully drained, err 4'b0001; tuser on last beat -> err 4'b1000.
//  5 tvalid toggling every other cycle, then tkeep 4'b0101 on last beat
//    -> gaps give a result identical to test 1; bad tkeep gives err 4'b0010.
//  6 Reset after 2 payload beats -> no status_valid, counters 0, hdr_ready 1 after release;
//    next good pkt -> good_count = 1.

Source files
------------

// File: rtl/fyp_udp_rx_checker_if.sv
// Header and payload channels between the UDP/IP parser and the receive checker.
// The master drives header fields and payload beats. The slave returns the two ready signals.
interface fyp_udp_rx_checker_if;
    logic        s_udp_hdr_valid;
    logic        s_udp_hdr_ready;
    logic [47:0] s_eth_dest_mac;
    logic [31:0] s_ip_dest_ip;
    logic [15:0] s_udp_source_port;
    logic [15:0] s_udp_dest_port;
    logic [15:0] s_udp_length;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        s_axis_tuser;

    modport master (
        output s_udp_hdr_valid, s_eth_dest_mac, s_ip_dest_ip, s_udp_source_port,
               s_udp_dest_port, s_udp_length, s_axis_tdata, s_axis_tkeep,
               s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_udp_hdr_ready, s_axis_tready
    );

    modport slave (
        input  s_udp_hdr_valid, s_eth_dest_mac, s_ip_dest_ip, s_udp_source_port,
               s_udp_dest_port, s_udp_length, s_axis_tdata, s_axis_tkeep,
               s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_udp_hdr_ready, s_axis_tready
    );
endinterface

// File: rtl/fyp_udp_rx_checker.sv
// Loopback receive checker: validates header fields, payload bytes and length against the
// generator settings, then reports per-packet status and keeps good/bad packet counters.
module fyp_udp_rx_checker #(
    parameter logic [47:0] EXP_MAC_DST = 48'h00E04C68088F,
    parameter logic [31:0] EXP_IP_DST  = 32'hc0a80105,
    parameter logic [15:0] EXP_UDP_SRC = 16'h1111,
    parameter logic [15:0] EXP_UDP_DST = 16'h2222,
    parameter logic [7:0]  EXP_DATA    = 8'h11
) (
    input  logic                        clk,
    input  logic                        reset,
    fyp_udp_rx_checker_if.slave         rx,
    output logic                        status_valid,
    output logic [3:0]                  status_err,
    output logic [31:0]                 good_count,
    output logic [31:0]                 bad_count,
    output logic                        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_STATUS  = 2'd2
    } state_t;

    function automatic logic [2:0] keep_count(input logic [3:0] keep);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'd0, keep[i]};
        end
        return n;
    endfunction

    // Only lane-0-anchored contiguous enables are legal; an empty beat is an error too.
    function automatic logic keep_legal(input logic [3:0] keep);
        logic ok;
        case (keep)
            4'b0001, 4'b0011, 4'b0111, 4'b1111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic lanes_bad(input logic [31:0] data, input logic [3:0] keep);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keep[i] && (data[i*8 +: 8] != EXP_DATA)) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    state_t      state_r, state_s;
    logic        hdr_ready_r, hdr_ready_s;
    logic        tready_r, tready_s;
    logic        hdr_err_r, hdr_err_s;
    logic        len_err_r, len_err_s;
    logic        pay_err_r, pay_err_s;
    logic        usr_err_r, usr_err_s;
    logic [15:0] exp_len_r, exp_len_s;
    logic [15:0] byte_cnt_r, byte_cnt_s;
    logic        status_valid_r, status_valid_s;
    logic [3:0]  status_err_r, status_err_s;
    logic [31:0] good_count_r, good_count_s;
    logic [31:0] bad_count_r, bad_count_s;
    logic        busy_r, busy_s;

    logic        hdr_fire_s;
    logic        beat_fire_s;
    logic        hdr_mismatch_s;
    logic        beat_pay_bad_s;
    logic [16:0] cnt_sum_s;
    logic [15:0] cnt_sat_s;

    assign rx.s_udp_hdr_ready = hdr_ready_r;
    assign rx.s_axis_tready   = tready_r;
    assign status_valid       = status_valid_r;
    assign status_err         = status_err_r;
    assign good_count         = good_count_r;
    assign bad_count          = bad_count_r;
    assign busy               = busy_r;

    // Per-beat and per-header decode shared by the next-state logic.
    always_comb begin
        hdr_fire_s     = rx.s_udp_hdr_valid & hdr_ready_r;
        beat_fire_s    = rx.s_axis_tvalid & tready_r;
        hdr_mismatch_s = (rx.s_eth_dest_mac    != EXP_MAC_DST) |
                         (rx.s_ip_dest_ip      != EXP_IP_DST)  |
                         (rx.s_udp_source_port != EXP_UDP_SRC) |
                         (rx.s_udp_dest_port   != EXP_UDP_DST);
        beat_pay_bad_s = lanes_bad(rx.s_axis_tdata, rx.s_axis_tkeep) |
                         ~keep_legal(rx.s_axis_tkeep);
        cnt_sum_s      = {1'b0, byte_cnt_r} + {14'd0, keep_count(rx.s_axis_tkeep)};
        cnt_sat_s      = cnt_sum_s[16] ? 16'hFFFF : cnt_sum_s[15:0];
    end

    // Next-state and next-register values for the packet FSM.
    always_comb begin
        state_s        = state_r;
        hdr_ready_s    = hdr_ready_r;
        tready_s       = tready_r;
        hdr_err_s      = hdr_err_r;
        len_err_s      = len_err_r;
        pay_err_s      = pay_err_r;
        usr_err_s      = usr_err_r;
        exp_len_s      = exp_len_r;
        byte_cnt_s     = byte_cnt_r;
        status_valid_s = 1'b0;
        status_err_s   = status_err_r;
        good_count_s   = good_count_r;
        bad_count_s    = bad_count_r;
        busy_s         = busy_r;

        case (state_r)
            ST_IDLE: begin
                tready_s = 1'b0;
                if (hdr_fire_s) begin
                    hdr_err_s   = hdr_mismatch_s;
                    if (rx.s_udp_length < 16'd8) begin
                        len_err_s = 1'b1;
                        exp_len_s = 16'd0;
                    end else begin
                        len_err_s = 1'b0;
                        exp_len_s = rx.s_udp_length - 16'd8;
                    end
                    pay_err_s   = 1'b0;
                    usr_err_s   = 1'b0;
                    byte_cnt_s  = 16'd0;
                    hdr_ready_s = 1'b0;
                    tready_s    = 1'b1;
                    busy_s      = 1'b1;
                    state_s     = ST_PAYLOAD;
                end else begin
                    hdr_ready_s = 1'b1;
                    busy_s      = 1'b0;
                end
            end

            ST_PAYLOAD: begin
                if (beat_fire_s) begin
                    byte_cnt_s = cnt_sat_s;
                    pay_err_s  = pay_err_r | beat_pay_bad_s;
                    usr_err_s  = usr_err_r | rx.s_axis_tuser;
                    if (rx.s_axis_tlast) begin
                        // Status is built from the final beat's contribution so it can
                        // be registered on the tlast edge itself.
                        status_err_s   = {usr_err_s,
                                          len_err_r | (byte_cnt_s != exp_len_r),
                                          pay_err_s,
                                          hdr_err_r};
                        status_valid_s = 1'b1;
                        tready_s       = 1'b0;
                        state_s        = ST_STATUS;
                        if (status_err_s == 4'd0) begin
                            good_count_s = good_count_r + 32'd1;
                        end else begin
                            bad_count_s  = bad_count_r + 32'd1;
                        end
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end

            ST_STATUS: begin
                hdr_ready_s = 1'b1;
                tready_s    = 1'b0;
                busy_s      = 1'b0;
                state_s     = ST_IDLE;
            end

            default: begin
                hdr_ready_s = 1'b0;
                tready_s    = 1'b0;
                busy_s      = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            hdr_ready_r    <= 1'b0;
            tready_r       <= 1'b0;
            hdr_err_r      <= 1'b0;
            len_err_r      <= 1'b0;
            pay_err_r      <= 1'b0;
            usr_err_r      <= 1'b0;
            exp_len_r      <= 16'd0;
            byte_cnt_r     <= 16'd0;
            status_valid_r <= 1'b0;
            status_err_r   <= 4'd0;
            good_count_r   <= 32'd0;
            bad_count_r    <= 32'd0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            hdr_ready_r    <= hdr_ready_s;
            tready_r       <= tready_s;
            hdr_err_r      <= hdr_err_s;
            len_err_r      <= len_err_s;
            pay_err_r      <= pay_err_s;
            usr_err_r      <= usr_err_s;
            exp_len_r      <= exp_len_s;
            byte_cnt_r     <= byte_cnt_s;
            status_valid_r <= status_valid_s;
            status_err_r   <= status_err_s;
            good_count_r   <= good_count_s;
            bad_count_r    <= bad_count_s;
            busy_r         <= busy_s;
        end
    end

endmodule

// File: tb/tb_fyp_udp_rx_checker.sv
// Self-checking bench for fyp_udp_rx_checker: directed packets plus randomized packets
// scored against a byte-level reference model.
module tb_fyp_udp_rx_checker;

    localparam logic [47:0] MAC = 48'h00E04C68088F;
    localparam logic [31:0] IP  = 32'hc0a80105;
    localparam logic [15:0] SP  = 16'h1111;
    localparam logic [15:0] DP  = 16'h2222;

    logic        clk = 1'b0;
    logic        reset;
    logic        status_valid;
    logic [3:0]  status_err;
    logic [31:0] good_count;
    logic [31:0] bad_count;
    logic        busy;

    always #5 clk = ~clk;

    fyp_udp_rx_checker_if rx();

    fyp_udp_rx_checker dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .status_valid (status_valid),
        .status_err   (status_err),
        .good_count   (good_count),
        .bad_count    (bad_count),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_good = 0;
    int exp_bad  = 0;

    logic [47:0] h_mac;
    logic [31:0] h_ip;
    logic [15:0] h_sp, h_dp, h_len;
    logic [31:0] bd[$];
    logic [3:0]  bk[$];
    logic        bu[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: walk the bytes the packet actually carries and apply the checker rules.
    function automatic logic [3:0] model_err();
        int   total;
        logic pe, ue, le, he;
        total = 0; pe = 1'b0; ue = 1'b0;
        for (int i = 0; i < bd.size(); i++) begin
            if (!(bk[i] inside {4'h1, 4'h3, 4'h7, 4'hF})) pe = 1'b1;
            for (int l = 0; l < 4; l++) begin
                if (bk[i][l]) begin
                    total++;
                    if (bd[i][l*8 +: 8] != 8'h11) pe = 1'b1;
                end
            end
            if (bu[i]) ue = 1'b1;
        end
        he = (h_mac != MAC) || (h_ip != IP) || (h_sp != SP) || (h_dp != DP);
        le = (h_len < 16'd8) ? 1'b1 : (total != (int'(h_len) - 8));
        return {ue, le, pe, he};
    endfunction

    task automatic set_hdr(input logic [47:0] m, input logic [31:0] i, input logic [15:0] s,
                           input logic [15:0] d, input logic [15:0] l);
        h_mac = m; h_ip = i; h_sp = s; h_dp = d; h_len = l;
    endtask

    task automatic build(input int nbytes, input int bad_byte, input int user_beat, input bit bad_keep);
        int nb;
        logic [31:0] tmp;
        nb = (nbytes + 3) / 4;
        bd.delete(); bk.delete(); bu.delete();
        for (int b = 0; b < nb; b++) begin
            int k;
            logic [3:0]  keep;
            logic [31:0] d;
            k = nbytes - 4*b;
            if (k > 4) k = 4;
            keep = 4'((1 << k) - 1);
            d = $urandom;
            for (int l = 0; l < 4; l++) if (keep[l]) d[l*8 +: 8] = 8'h11;
            bd.push_back(d); bk.push_back(keep); bu.push_back(b == user_beat);
        end
        if (bad_byte >= 0 && bad_byte < nbytes) begin
            tmp = bd[bad_byte/4];
            tmp[(bad_byte%4)*8 +: 8] = 8'h12;
            bd[bad_byte/4] = tmp;
        end
        if (bad_keep) begin
            bk[nb-1] = 4'b0101;
            bd[nb-1] = 32'h11111111;
        end
    endtask

    task automatic send_hdr();
        int t;
        check_eq("tready_idle", rx.s_axis_tready, 1'b0);
        rx.s_udp_hdr_valid   = 1'b1;
        rx.s_eth_dest_mac    = h_mac;
        rx.s_ip_dest_ip      = h_ip;
        rx.s_udp_source_port = h_sp;
        rx.s_udp_dest_port   = h_dp;
        rx.s_udp_length      = h_len;
        t = 0;
        while (!rx.s_udp_hdr_ready && t < 50) begin @(negedge clk); t++; end
        check_eq("hdr_ready", rx.s_udp_hdr_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        rx.s_udp_hdr_valid = 1'b0;
        rx.s_udp_length    = 16'($urandom);
        check_eq("hdr_ready_low_payload", rx.s_udp_hdr_ready, 1'b0);
        check_eq("busy_payload", busy, 1'b1);
    endtask

    task automatic send_beat(input int i, input bit gap);
        int t;
        if (gap) begin
            rx.s_axis_tvalid = 1'b0;
            rx.s_axis_tlast  = 1'b1;
            @(negedge clk);
        end
        rx.s_axis_tvalid = 1'b1;
        rx.s_axis_tdata  = bd[i];
        rx.s_axis_tkeep  = bk[i];
        rx.s_axis_tlast  = (i == bd.size() - 1);
        rx.s_axis_tuser  = bu[i];
        t = 0;
        while (!rx.s_axis_tready && t < 50) begin @(negedge clk); t++; end
        check_eq("beat_tready", rx.s_axis_tready, 1'b1);
        check_eq("no_early_status", status_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        rx.s_axis_tvalid = 1'b0;
        rx.s_axis_tlast  = 1'b0;
        rx.s_axis_tuser  = 1'b0;
    endtask

    task automatic run_pkt(input string tag, input int gap_mode);
        logic [3:0] e;
        e = model_err();
        if (e == 4'd0) exp_good++; else exp_bad++;
        send_hdr();
        for (int i = 0; i < bd.size(); i++) begin
            send_beat(i, (gap_mode == 1) ? 1'b1 :
                         (gap_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0);
        end
        check_eq({tag, "_status_valid"}, status_valid, 1'b1);
        check_eq({tag, "_status_err"}, status_err, e);
        check_eq({tag, "_good_count"}, good_count, 32'(exp_good));
        check_eq({tag, "_bad_count"}, bad_count, 32'(exp_bad));
        @(negedge clk);
        check_eq({tag, "_status_pulse_end"}, status_valid, 1'b0);
        check_eq({tag, "_status_err_hold"}, status_err, e);
        check_eq({tag, "_busy_done"}, busy, 1'b0);
        check_eq({tag, "_hdr_ready_back"}, rx.s_udp_hdr_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        rx.s_udp_hdr_valid = 1'b0; rx.s_eth_dest_mac = 48'd0; rx.s_ip_dest_ip = 32'd0;
        rx.s_udp_source_port = 16'd0; rx.s_udp_dest_port = 16'd0; rx.s_udp_length = 16'd0;
        rx.s_axis_tdata = 32'd0; rx.s_axis_tkeep = 4'd0; rx.s_axis_tvalid = 1'b0;
        rx.s_axis_tlast = 1'b0; rx.s_axis_tuser = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hdr_ready", rx.s_udp_hdr_ready, 1'b0);
        check_eq("rst_tready", rx.s_axis_tready, 1'b0);
        check_eq("rst_status", {status_valid, status_err, busy}, 6'd0);
        check_eq("rst_counts", {good_count, bad_count}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("hdr_ready_after_rst", rx.s_udp_hdr_ready, 1'b1);

        set_hdr(MAC, IP, SP, DP, 16'h001A); build(18, -1, -1, 1'b0); run_pkt("t1_good", 0);
        set_hdr(MAC, IP, SP, DP, 16'h001A); build(18, 7, -1, 1'b0);  run_pkt("t2_byte7", 0);
        set_hdr(MAC, IP, SP, DP, 16'h001B); build(18, -1, -1, 1'b0); run_pkt("t3_len_long", 0);
        set_hdr(MAC, IP, SP, DP, 16'h0005); build(1, -1, -1, 1'b0);  run_pkt("t3_len_short", 0);
        set_hdr(MAC, IP, SP, 16'h2223, 16'h001A); build(18, -1, -1, 1'b0); run_pkt("t4_udp_dst", 0);
        set_hdr(MAC, IP, SP, DP, 16'h001A); build(18, -1, 4, 1'b0);  run_pkt("t4_tuser", 0);
        set_hdr(MAC, IP, SP, DP, 16'h001A); build(18, -1, -1, 1'b0); run_pkt("t5_gaps", 1);
        set_hdr(MAC, IP, SP, DP, 16'h001A); build(18, -1, -1, 1'b1); run_pkt("t5_badkeep", 1);

        // Reset in the middle of a packet.
        set_hdr(MAC, IP, SP, DP, 16'h001A); build(18, -1, -1, 1'b0);
        send_hdr();
        send_beat(0, 1'b0);
        send_beat(1, 1'b0);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("midrst_no_status", status_valid, 1'b0);
        check_eq("midrst_counts", {good_count, bad_count}, 64'd0);
        check_eq("midrst_hdr_ready", rx.s_udp_hdr_ready, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_hdr_ready_release", rx.s_udp_hdr_ready, 1'b1);
        check_eq("midrst_tready", rx.s_axis_tready, 1'b0);
        exp_good = 0; exp_bad = 0;
        set_hdr(MAC, IP, SP, DP, 16'h001A); build(18, -1, -1, 1'b0); run_pkt("t6_after_rst", 0);

        for (int p = 0; p < 40; p++) begin
            int nbytes, r;
            logic [47:0] m; logic [31:0] i; logic [15:0] s, d, l;
            nbytes = $urandom_range(1, 24);
            m = MAC; i = IP; s = SP; d = DP;
            case ($urandom_range(0, 11))
                0: m = MAC ^ 48'(1 << $urandom_range(0, 47));
                1: i = IP ^ 32'(1 << $urandom_range(0, 31));
                2: s = SP ^ 16'(1 << $urandom_range(0, 15));
                3: d = DP ^ 16'(1 << $urandom_range(0, 15));
                default: ;
            endcase
            r = $urandom_range(0, 9);
            if (r == 0)      l = 16'($urandom_range(0, 7));
            else if (r == 1) l = 16'(8 + nbytes + $urandom_range(1, 3));
            else if (r == 2) l = 16'(8 + nbytes - 1);
            else             l = 16'(8 + nbytes);
            set_hdr(m, i, s, d, l);
            build(nbytes,
                  ($urandom_range(0, 5) == 0) ? $urandom_range(0, nbytes - 1) : -1,
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, (nbytes - 1) / 4) : -1,
                  ($urandom_range(0, 7) == 0));
            run_pkt("rand", 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
